// File: rtl/key_arbiter.sv
// Front-panel key controller: per-key debounce, press events, round-robin arbitration into a
// first-word-fallthrough FIFO drained by valid/ready. Optional auto-repeat: define KEY_REPEAT_EN.
module key_arbiter #(
    parameter  int NKEYS  = 4,
    parameter  int DELAY  = 8,
    parameter  int DEPTH  = 4,
    parameter  int REPEAT = 1024,
    localparam int KW     = $clog2(NKEYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] keys,
    output logic [KW-1:0]    code,
    output logic             valid,
    input  logic             ready,
    output logic             overflow
);

    localparam int         AW  = $clog2(DEPTH);
    localparam int         CW  = AW + 1;
    localparam logic [7:0] DLY = 8'(DELAY);

    logic [NKEYS-1:0] stable;
    logic [NKEYS-1:0] stable_d;
    logic [NKEYS-1:0] press;
    logic [NKEYS-1:0] key_event;
    logic [NKEYS-1:0] pending;
    logic [NKEYS-1:0] grant_vec;
    logic [NKEYS-1:0] merge;

    logic [KW-1:0]    ptr;
    logic [KW-1:0]    grant_idx;
    logic [KW-1:0]    scan_idx;
    logic             grant_any;

    logic [KW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [KW-1:0]    head_next;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // ------------------------------------------------------------------
    // Per-key debounce and event generation
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        logic [7:0] cnt_h;
        logic [7:0] cnt_l;
        logic       stable_q;

        // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_h    <= '0;
                cnt_l    <= '0;
                stable_q <= 1'b0;
            end else begin
                if (keys[i]) begin
                    cnt_h <= (cnt_h == DLY) ? cnt_h : cnt_h + 8'd1;
                    cnt_l <= '0;
                end else begin
                    cnt_l <= (cnt_l == DLY) ? cnt_l : cnt_l + 8'd1;
                    cnt_h <= '0;
                end

                if (cnt_h == DLY) begin
                    stable_q <= 1'b1;
                end else if (cnt_l == DLY) begin
                    stable_q <= 1'b0;
                end
            end
        end

        assign stable[i] = stable_q;
        assign press[i]  = stable_q & ~stable_d[i];

`ifdef KEY_REPEAT_EN
        localparam int HW = $clog2(REPEAT);
        logic [HW-1:0] hold;

        // hold is the age of the current press modulo REPEAT; age 0 is the press cycle itself.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold <= '0;
            end else if (!stable_q) begin
                hold <= '0;
            end else if (press[i]) begin
                hold <= HW'(1);
            end else if (hold == HW'(REPEAT - 1)) begin
                hold <= '0;
            end else begin
                hold <= hold + HW'(1);
            end
        end

        assign key_event[i] = press[i] | (stable_q & stable_d[i] & (hold == '0));
`else
        assign key_event[i] = press[i];
`endif
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: first pending key at or after ptr+1
    // ------------------------------------------------------------------
    assign fifo_full = (count == CW'(DEPTH));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        grant_vec = '0;
        if (!fifo_full) begin
            for (int k = 1; k <= NKEYS; k++) begin
                scan_idx = KW'((int'(ptr) + k) % NKEYS);
                if (!grant_any && pending[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // An event on a key that is already waiting and not being granted folds into that request.
    assign merge = key_event & pending & ~grant_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            ptr      <= KW'(NKEYS - 1);
        end else begin
            stable_d <= stable;
            pending  <= (pending & ~grant_vec) | key_event;
            overflow <= |merge;
            if (grant_any) begin
                ptr <= grant_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word-fallthrough FIFO with registered head and valid
    // ------------------------------------------------------------------
    assign push       = grant_any;
    assign pop        = valid & ready;
    assign rd_next    = rd_ptr + AW'(pop);
    assign count_next = count + CW'(push) - CW'(pop);

    // The entry written this cycle becomes the head when it lands on the next read slot.
    assign head_next  = (push && (wr_ptr == rd_next)) ? grant_idx : mem[rd_next];

    // NOTE: the storage array has no reset; count and valid gate it, and an unreset array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            code   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            valid  <= (count_next != '0);
            if (count_next != '0) begin
                code <= head_next;
            end
        end
    end

endmodule

// File: tb/tb_key_arbiter.sv
// Self-checking bench for key_arbiter: directed scenarios plus random key/ready traffic, scored
// against a behavioural model. Define KEY_REPEAT_EN to also exercise auto-repeat (REPEAT=100).
module tb_key_arbiter;

    localparam int NKEYS = 4;
    localparam int DELAY = 8;
    localparam int DEPTH = 4;
`ifdef KEY_REPEAT_EN
    localparam int REPEAT = 100;
    localparam bit REP_EN = 1'b1;
`else
    localparam int REPEAT = 1024;
    localparam bit REP_EN = 1'b0;
`endif
    localparam int KW = $clog2(NKEYS);

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             ready = 1'b0;
    logic [NKEYS-1:0] keys  = '0;
    logic [KW-1:0]    code;
    logic             valid;
    logic             overflow;

    key_arbiter #(
        .NKEYS (NKEYS),
        .DELAY (DELAY),
        .DEPTH (DEPTH),
        .REPEAT(REPEAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .keys    (keys),
        .code    (code),
        .valid   (valid),
        .ready   (ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_pops = 0;
    int n_ovf  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a key level is believed once it has been seen on DELAY
    // consecutive samples; events, pending requests and the queue follow from that.
    // ------------------------------------------------------------------
    int run_len    [NKEYS];
    bit run_val    [NKEYS];
    bit m_stable   [NKEYS];
    bit m_stable_d [NKEYS];
    bit m_pend     [NKEYS];
    int m_age      [NKEYS];
    int m_ptr;
    int m_count;
    bit m_ovf;
    int exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < NKEYS; i++) begin
            run_len[i]    = 0;
            run_val[i]    = 1'b0;
            m_stable[i]   = 1'b0;
            m_stable_d[i] = 1'b0;
            m_pend[i]     = 1'b0;
            m_age[i]      = 0;
        end
        m_ptr   = NKEYS - 1;
        m_count = 0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    // Advances the model across one rising edge, using the inputs present at that edge.
    task automatic model_step();
        bit ev [NKEYS];
        int g;
        bit pop;
        bit nst;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NKEYS; i++) begin
            ev[i] = m_stable[i] && (REP_EN ? (m_age[i] % REPEAT == 0) : !m_stable_d[i]);
        end
        g = -1;
        if (m_count < DEPTH) begin
            for (int k = 1; k <= NKEYS; k++) begin
                int idx = (m_ptr + k) % NKEYS;
                if (g < 0 && m_pend[idx]) g = idx;
            end
        end
        m_ovf = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (ev[i] && m_pend[i] && i != g) m_ovf = 1'b1;
            m_pend[i] = (m_pend[i] && i != g) || ev[i];
        end
        pop = (m_count > 0) && ready;
        if (g >= 0) begin
            exp_q.push_back(g);
            m_ptr = g;
            m_count++;
        end
        if (pop) m_count--;
        for (int i = 0; i < NKEYS; i++) begin
            nst           = (run_len[i] >= DELAY) ? run_val[i] : m_stable[i];
            m_age[i]      = (nst && m_stable[i]) ? m_age[i] + 1 : 0;
            m_stable_d[i] = m_stable[i];
            m_stable[i]   = nst;
            if (keys[i] == run_val[i]) begin
                if (run_len[i] < DELAY) run_len[i]++;
            end else begin
                run_val[i] = keys[i];
                run_len[i] = 1;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares the DUT against the model half a cycle after each edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        check("valid", int'(valid), int'(m_count != 0));
        check("overflow", int'(overflow), int'(m_ovf));
        if (overflow) n_ovf++;
        if (valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL code: got %0d, expected no entry (t=%0t)", code, $time);
            end else begin
                check("code", int'(code), exp_q[0]);
                if (ready) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_reset();
        ticks(n);
        rst = 1'b0;
    endtask

    // Runs exactly 'limit' cycles; cyc is the first cycle after which valid was high, 0 if never.
    task automatic first_valid(input int limit, output int cyc);
        cyc = 0;
        for (int c = 1; c <= limit; c++) begin
            tick();
            if (valid && cyc == 0) cyc = c;
        end
    endtask

    int dwell [NKEYS];
    int cyc;
    int p0;
    int o0;
    int rphase;
    bit saw_valid;

    initial begin
        model_reset();
        do_reset(3);

        // Single press: latency DELAY+3, one entry, nothing on release.
        keys  = 4'b0001;
        ready = 1'b1;
        p0    = n_pops;
        first_valid(20, cyc);
        check("t1_latency", cyc, DELAY + 3);
        keys = '0;
        ticks(20);
        check("t1_entries", n_pops - p0, 1);

        // Bouncing key never settles long enough to count.
        saw_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (c % 3 == 0) keys[1] = ~keys[1];
            tick();
            if (valid) saw_valid = 1'b1;
        end
        check("t2_no_event", int'(saw_valid), 0);
        keys = '0;
        ticks(12);

        // Simultaneous presses drain round-robin from key 0.
        do_reset(2);
        p0   = n_pops;
        keys = '1;
        ticks(20);
        keys = '0;
        ticks(15);
        check("t3_all_four", n_pops - p0, 4);
        p0   = n_pops;
        keys = 4'b0101;
        ticks(20);
        keys = '0;
        ticks(15);
        check("t3_pair", n_pops - p0, 2);

        // Full FIFO blocks the fifth request; a repeat press on it merges.
        ready = 1'b0;
        keys  = '1;
        ticks(15);
        keys = '0;
        ticks(12);
        keys = 4'b0001;
        ticks(12);
        keys = '0;
        ticks(12);
        o0   = n_ovf;
        keys = 4'b0001;
        ticks(12);
        keys = '0;
        ticks(12);
        check("t4_overflow_pulses", n_ovf - o0, 1);
        check("t4_valid_while_full", int'(valid), 1);
        p0    = n_pops;
        ready = 1'b1;
        ticks(15);
        check("t4_drained", n_pops - p0, 5);

        // Reset with entries queued and key 3 held through it.
        ready = 1'b0;
        keys  = 4'b0111;
        ticks(15);
        keys = 4'b1000;
        ticks(4);
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_valid_in_reset", int'(valid), 0);
            check("t5_code_in_reset", int'(code), 0);
        end
        rst = 1'b0;
        first_valid(20, cyc);
        check("t5_latency", cyc, DELAY + 3);
        check("t5_code", int'(code), 3);
        keys  = '0;
        ready = 1'b1;
        ticks(15);

        // Random key traffic with glitches, varying back-pressure and one mid-run reset.
        for (int i = 0; i < NKEYS; i++) dwell[i] = $urandom_range(0, 20);
        rphase = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NKEYS; i++) begin
                if (dwell[i] == 0) begin
                    keys[i]  = ~keys[i];
                    dwell[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DELAY - 1)
                                                           : $urandom_range(DELAY, 4 * DELAY);
                end else begin
                    dwell[i]--;
                end
            end
            if (c % 200 == 0) rphase = $urandom_range(0, 2);
            ready = (rphase == 0) ? 1'b0 : ($urandom_range(0, rphase) != 0);
            if (c == 1500) do_reset(2);
            else tick();
        end
        keys  = '0;
        ready = 1'b1;
        ticks(40);

`ifdef KEY_REPEAT_EN
        // Held key auto-repeats every REPEAT cycles.
        do_reset(2);
        p0   = n_pops;
        keys = 4'b0001;
        ticks(350);
        keys = '0;
        ticks(20);
        check("t7_repeat_events", n_pops - p0, 4);
`endif

        keys  = '0;
        ready = 1'b1;
        ticks(40);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
